// File: rtl/avalon_sdram_tester_if.sv
// avalon_sdram_tester_if
//   Avalon-MM bus between the SDRAM tester (master) and the SDRAM controller
//   slave port. Parameterised by word-address width AW and data width DW.
//
//   Handshake: a request (avm_read or avm_write) is accepted on a rising
//   clock edge where it is high and avm_waitrequest is low. While
//   avm_waitrequest is high the master keeps the request, address and write
//   data unchanged. Read data returns later, in request order, qualified by
//   avm_readdatavalid; there is no back-pressure on returned data.
//
//   Signals
//     avm_read, avm_write   master -> slave   request strobes (never both high)
//     avm_address  [AW]     master -> slave   word address
//     avm_writedata[DW]     master -> slave   write data
//     avm_byteenable[DW/8]  master -> slave   byte lanes
//     avm_waitrequest       slave  -> master  stall
//     avm_readdata [DW]     slave  -> master  read data
//     avm_readdatavalid     slave  -> master  read data qualifier
interface avalon_sdram_tester_if #(
  parameter int AW = 24,
  parameter int DW = 16
);
  logic            avm_read;
  logic            avm_write;
  logic [AW-1:0]   avm_address;
  logic [DW-1:0]   avm_writedata;
  logic [DW/8-1:0] avm_byteenable;
  logic            avm_waitrequest;
  logic [DW-1:0]   avm_readdata;
  logic            avm_readdatavalid;

  modport master (
    output avm_read,
    output avm_write,
    output avm_address,
    output avm_writedata,
    output avm_byteenable,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_read,
    input  avm_write,
    input  avm_address,
    input  avm_writedata,
    input  avm_byteenable,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );
endinterface

// File: rtl/avalon_sdram_tester.sv
// avalon_sdram_tester
//   Avalon-MM master that exercises an SDRAM controller: on start it writes a
//   deterministic pattern to NUM_WORDS consecutive word addresses starting at
//   BASE_ADDR, reads the range back with up to MAX_OUTSTANDING pipelined reads,
//   compares every returned word and reports pass / error count / first
//   failing address.
//
//   Optional feature macro: SDRAM_TESTER_LFSR_EN
//     undefined : pat(i) = {DW/16{SEED ^ i[15:0]}}
//     defined   : pattern comes from a 16-bit Galois LFSR
//                 (x^16+x^14+x^13+x^11+1) seeded with SEED (0 -> 1); one LFSR
//                 steps per accepted write, a twin steps per returned word.
//
//   Ports
//     clk, reset      clock, synchronous active-high reset
//     start           1-cycle pulse, honoured only when idle
//     busy            high in every state except IDLE
//     done            1-cycle pulse at the end of a test
//     pass            last test had no errors; held until next start
//     err_cnt         saturating mismatch count
//     first_err_addr  address of the first mismatch (0 if none)
//     dbg_state       current FSM state (IDLE=0 WRITE=1 READ=2 DRAIN=3 FINISH=4)
//     avm             Avalon-MM master port (see avalon_sdram_tester_if)
module avalon_sdram_tester #(
  parameter int            AW              = 24,
  parameter int            DW              = 16,
  parameter int            NUM_WORDS       = 256,
  parameter logic [AW-1:0] BASE_ADDR       = '0,
  parameter logic [15:0]   SEED            = 16'hA5C3,
  parameter int            MAX_OUTSTANDING = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [15:0]                  err_cnt,
  output logic [AW-1:0]                first_err_addr,
  output logic [2:0]                   dbg_state,
  avalon_sdram_tester_if.master        avm
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRITE  = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  // Index counters must cover both the address range and the 16 bits the
  // XOR pattern uses. They never need to reach NUM_WORDS: each phase ends on
  // acceptance of index NUM_WORDS-1.
  localparam int CW = (AW > 16) ? AW : 16;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] OUT_CAP = OW'(MAX_OUTSTANDING);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] wr_idx_q, wr_idx_d;
  logic [CW-1:0] rd_idx_q, rd_idx_d;
  logic [CW-1:0] chk_idx_q, chk_idx_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic [AW-1:0] first_err_addr_q, first_err_addr_d;
  logic          pass_q, pass_d;

  logic          wr_req, rd_req, wr_acc, rd_acc;
  logic          chk_en, spurious, mismatch;
  logic [15:0]   wr_pat16, chk_pat16;
  logic [DW-1:0] wr_data, chk_data;
  logic [15:0]   err_base;

`ifdef SDRAM_TESTER_LFSR_EN
  localparam logic [15:0] LFSR_SEED = (SEED == 16'h0) ? 16'h0001 : SEED;

  logic [15:0] wr_lfsr_q, wr_lfsr_d;
  logic [15:0] chk_lfsr_q, chk_lfsr_d;

  // Right-shifting Galois form; 16'hB400 holds the x^16, x^14, x^13, x^11 taps.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  assign wr_pat16  = wr_lfsr_q;
  assign chk_pat16 = chk_lfsr_q;
`else
  assign wr_pat16  = SEED ^ wr_idx_q[15:0];
  assign chk_pat16 = SEED ^ chk_idx_q[15:0];
`endif

  assign wr_data  = {(DW/16){wr_pat16}};
  assign chk_data = {(DW/16){chk_pat16}};

  // Request strobes depend only on registered state, so they cannot change
  // while the slave stalls: outst only grows on an accepted read and the
  // indices only move on acceptance.
  assign wr_req = (state_q == S_WRITE);
  assign rd_req = (state_q == S_READ) && (outst_q < OUT_CAP);
  assign wr_acc = wr_req && !avm.avm_waitrequest;
  assign rd_acc = rd_req && !avm.avm_waitrequest;

  // A returned word is only genuine while reads are in flight; anything else
  // is counted as an error without disturbing the check sequence.
  assign chk_en   = avm.avm_readdatavalid &&
                    ((state_q == S_READ) || (state_q == S_DRAIN)) &&
                    (outst_q != '0);
  assign spurious = avm.avm_readdatavalid && !chk_en;
  assign mismatch = chk_en && (avm.avm_readdata != chk_data);

  always_comb begin
    state_d          = state_q;
    wr_idx_d         = wr_idx_q;
    rd_idx_d         = rd_idx_q;
    chk_idx_d        = chk_idx_q;
    outst_d          = outst_q;
    err_base         = err_cnt_q;
    err_cnt_d        = err_cnt_q;
    first_err_addr_d = first_err_addr_q;
    pass_d           = pass_q;
`ifdef SDRAM_TESTER_LFSR_EN
    wr_lfsr_d        = wr_lfsr_q;
    chk_lfsr_d       = chk_lfsr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d          = S_WRITE;
          wr_idx_d         = '0;
          rd_idx_d         = '0;
          chk_idx_d        = '0;
          err_base         = '0;
          first_err_addr_d = '0;
          pass_d           = 1'b0;
`ifdef SDRAM_TESTER_LFSR_EN
          wr_lfsr_d        = LFSR_SEED;
          chk_lfsr_d       = LFSR_SEED;
`endif
        end
      end
      S_WRITE: begin
        if (wr_acc) begin
          wr_idx_d = wr_idx_q + 1'b1;
`ifdef SDRAM_TESTER_LFSR_EN
          wr_lfsr_d = lfsr_next(wr_lfsr_q);
`endif
          if (wr_idx_q == LAST_IDX) state_d = S_READ;
        end
      end
      S_READ: begin
        if (rd_acc) begin
          rd_idx_d = rd_idx_q + 1'b1;
          if (rd_idx_q == LAST_IDX) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (outst_q == '0) state_d = S_FINISH;
      end
      S_FINISH: begin
        pass_d  = (err_cnt_q == '0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Issue and return in the same cycle cancel out.
    case ({rd_acc, chk_en})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase

    if (chk_en) begin
      chk_idx_d = chk_idx_q + 1'b1;
`ifdef SDRAM_TESTER_LFSR_EN
      chk_lfsr_d = lfsr_next(chk_lfsr_q);
`endif
    end

    err_cnt_d = err_base;
    if (mismatch || spurious) begin
      if (err_base != 16'hFFFF) err_cnt_d = err_base + 1'b1;
      if (mismatch && (err_base == '0))
        first_err_addr_d = BASE_ADDR + chk_idx_q[AW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      wr_idx_q         <= '0;
      rd_idx_q         <= '0;
      chk_idx_q        <= '0;
      outst_q          <= '0;
      err_cnt_q        <= '0;
      first_err_addr_q <= '0;
      pass_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      wr_idx_q         <= wr_idx_d;
      rd_idx_q         <= rd_idx_d;
      chk_idx_q        <= chk_idx_d;
      outst_q          <= outst_d;
      err_cnt_q        <= err_cnt_d;
      first_err_addr_q <= first_err_addr_d;
      pass_q           <= pass_d;
    end
  end

`ifdef SDRAM_TESTER_LFSR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_lfsr_q  <= '0;
      chk_lfsr_q <= '0;
    end else begin
      wr_lfsr_q  <= wr_lfsr_d;
      chk_lfsr_q <= chk_lfsr_d;
    end
  end
`endif

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_FINISH);
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_addr_q;
  assign dbg_state      = state_q;

  // Address arithmetic wraps modulo 2**AW by truncation.
  assign avm.avm_read       = rd_req;
  assign avm.avm_write      = wr_req;
  assign avm.avm_address    = wr_req                 ? (BASE_ADDR + wr_idx_q[AW-1:0]) :
                              (state_q == S_READ)    ? (BASE_ADDR + rd_idx_q[AW-1:0]) :
                              '0;
  assign avm.avm_writedata  = wr_req ? wr_data : '0;
  assign avm.avm_byteenable = '1;

endmodule

// File: tb/tb_avalon_sdram_tester.sv
`timescale 1ns/1ps
module tb_avalon_sdram_tester;
  localparam int            AW    = 24;
  localparam int            DW    = 16;
  localparam int            NW    = 8;
  localparam int            MAXO  = 4;
  localparam logic [15:0]   SEED  = 16'hA5C3;
  localparam int            NW2   = 4;
  localparam logic [AW-1:0] BASE2 = 24'hFFFFFE;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;
  always #5 clk = ~clk;

  avalon_sdram_tester_if #(.AW(AW), .DW(DW)) bus ();
  avalon_sdram_tester_if #(.AW(AW), .DW(DW)) bus2 ();

  logic          busy, done, pass, busy2, done2, pass2;
  logic [15:0]   err_cnt, err_cnt2;
  logic [AW-1:0] first_err_addr, first_err_addr2;
  logic [2:0]    dbg_state, dbg_state2;

  avalon_sdram_tester #(.AW(AW), .DW(DW), .NUM_WORDS(NW), .BASE_ADDR('0),
                        .SEED(SEED), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt), .first_err_addr(first_err_addr),
    .dbg_state(dbg_state), .avm(bus)
  );

  avalon_sdram_tester #(.AW(AW), .DW(DW), .NUM_WORDS(NW2), .BASE_ADDR(BASE2),
                        .SEED(SEED), .MAX_OUTSTANDING(MAXO)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
    .pass(pass2), .err_cnt(err_cnt2), .first_err_addr(first_err_addr2),
    .dbg_state(dbg_state2), .avm(bus2)
  );

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] model_pat(input int i);
    logic [15:0] s;
`ifdef SDRAM_TESTER_LFSR_EN
    s = (SEED == 16'h0) ? 16'h0001 : SEED;
    for (int k = 0; k < i; k++) s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
`else
    s = SEED ^ 16'(i);
`endif
    return {(DW/16){s}};
  endfunction

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [AW+DW-1:0] exp_wr_q[$];
  logic [AW-1:0]    exp_rd_q[$];
  logic [40:0]      exp_res_q[$];
  logic [AW+DW-1:0] exp_wr2_q[$];
  logic [AW-1:0]    exp_rd2_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- slave model (main bus) ----------------
  typedef struct { logic [DW-1:0] data; int due; } ret_t;
  ret_t          ret_q[$];
  logic [DW-1:0] mem [0:255];
  int            cyc = 0;
  int            cfg_lat = 3, cfg_wpct = 0, cfg_stall_idx = -1, stall_left = 0, wr_seen = 0;
  logic [7:0]    cfg_corrupt = '0;
  bit            spurious_req = 0;

  always @(negedge clk) begin
    logic w;
    cyc++;
    if (reset) begin
      ret_q.delete();
      bus.avm_waitrequest   = 1'b0;
      bus.avm_readdatavalid = 1'b0;
      bus.avm_readdata      = '0;
    end else begin
      if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
        ret_t r;
        r = ret_q.pop_front();
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = r.data;
      end else if (spurious_req) begin
        spurious_req = 0;
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = DW'($urandom);
      end else begin
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = '0;
      end
      w = 1'b0;
      if (bus.avm_write && wr_seen == cfg_stall_idx && stall_left > 0) begin
        w = 1'b1;
        stall_left--;
      end else if ((bus.avm_read || bus.avm_write) && $urandom_range(99) < cfg_wpct) begin
        w = 1'b1;
      end
      bus.avm_waitrequest = w;
      if (bus.avm_write && !w) begin
        mem[bus.avm_address[7:0]] = bus.avm_writedata;
        wr_seen++;
      end
      if (bus.avm_read && !w) begin
        ret_t r;
        r.data = mem[bus.avm_address[7:0]] ^ (cfg_corrupt[bus.avm_address[2:0]] ? DW'(16'h0100) : DW'(0));
        r.due  = cyc + cfg_lat;
        ret_q.push_back(r);
      end
    end
  end

  // ---------------- slave model (wrap bus, ideal, latency 1) ----------------
  logic [DW-1:0] mem2 [0:3];
  bit            pend2 = 0;
  logic [1:0]    pend2_a = '0;

  always @(negedge clk) begin
    if (reset) begin
      pend2 = 0;
      bus2.avm_waitrequest   = 1'b0;
      bus2.avm_readdatavalid = 1'b0;
      bus2.avm_readdata      = '0;
    end else begin
      bus2.avm_readdatavalid = pend2;
      bus2.avm_readdata      = pend2 ? mem2[pend2_a] : '0;
      bus2.avm_waitrequest   = 1'b0;
      if (bus2.avm_write) mem2[bus2.avm_address[1:0]] = bus2.avm_writedata;
      pend2   = bus2.avm_read;
      pend2_a = bus2.avm_address[1:0];
    end
  end

  // ---------------- monitor (main bus) ----------------
  int            wr_acc_cnt = 0, rd_acc_cnt = 0, outst_m = 0, max_outst = 0;
  int            done_cnt = 0, stall_cycles = 0;
  bit            test_active = 0, chk_pass_next = 0, held_valid = 0;
  logic          exp_pass_next;
  logic [AW-1:0] held_addr;
  logic [DW-1:0] held_data;

  always begin
    @(negedge clk);
    #1;
    if (reset) begin
      outst_m = 0;
      held_valid = 0;
      chk_pass_next = 0;
      test_active = 0;
    end else begin
      bit acc_rd, real_rv;
      if (chk_pass_next) begin
        check("pass", pass, exp_pass_next);
        chk_pass_next = 0;
      end
      if (bus.avm_read || bus.avm_write)
        check("rd_wr_exclusive", bus.avm_read & bus.avm_write, 0);
      if (held_valid) begin
        check("stall_write_held", bus.avm_write, 1);
        check("stall_addr_stable", bus.avm_address, held_addr);
        check("stall_data_stable", bus.avm_writedata, held_data);
      end
      held_valid = bus.avm_write && bus.avm_waitrequest;
      if (held_valid) begin
        held_addr = bus.avm_address;
        held_data = bus.avm_writedata;
        stall_cycles++;
      end
      if (test_active && wr_acc_cnt == NW && rd_acc_cnt < NW && outst_m < MAXO)
        check("read_issue", bus.avm_read, 1);
      if (bus.avm_read) check("outst_cap", outst_m < MAXO, 1);
      if (bus.avm_write && !bus.avm_waitrequest) begin
        wr_acc_cnt++;
        if (exp_wr_q.size() == 0) fail_now("unexpected_write");
        else check("write_txn", {bus.avm_address, bus.avm_writedata}, exp_wr_q.pop_front());
      end
      acc_rd = bus.avm_read && !bus.avm_waitrequest;
      if (acc_rd) begin
        rd_acc_cnt++;
        if (exp_rd_q.size() == 0) fail_now("unexpected_read");
        else check("read_addr", bus.avm_address, exp_rd_q.pop_front());
      end
      real_rv = bus.avm_readdatavalid && outst_m > 0;
      outst_m = outst_m + (acc_rd ? 1 : 0) - (real_rv ? 1 : 0);
      if (outst_m > max_outst) max_outst = outst_m;
      if (done) begin
        done_cnt++;
        if (exp_res_q.size() == 0) fail_now("unexpected_done");
        else begin
          logic [40:0] r;
          r = exp_res_q.pop_front();
          check("err_cnt", err_cnt, r[39:24]);
          check("first_err_addr", first_err_addr, r[23:0]);
          exp_pass_next = r[40];
          chk_pass_next = 1;
        end
      end
    end
  end

  // ---------------- monitor (wrap bus) ----------------
  int done2_cnt = 0;
  bit chk_pass2 = 0;

  always begin
    @(negedge clk);
    #1;
    if (!reset) begin
      if (chk_pass2) begin
        check("wrap_pass", pass2, 1);
        chk_pass2 = 0;
      end
      if (bus2.avm_write && !bus2.avm_waitrequest) begin
        if (exp_wr2_q.size() == 0) fail_now("wrap_unexpected_write");
        else check("wrap_write_txn", {bus2.avm_address, bus2.avm_writedata}, exp_wr2_q.pop_front());
      end
      if (bus2.avm_read && !bus2.avm_waitrequest) begin
        if (exp_rd2_q.size() == 0) fail_now("wrap_unexpected_read");
        else check("wrap_read_addr", bus2.avm_address, exp_rd2_q.pop_front());
      end
      if (done2) begin
        done2_cnt++;
        check("wrap_err_cnt", err_cnt2, 0);
        check("wrap_first_err", first_err_addr2, 0);
        chk_pass2 = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_expect(input logic [7:0] corrupt);
    int e = 0;
    int f = -1;
    for (int i = 0; i < NW; i++) begin
      exp_wr_q.push_back({AW'(i), model_pat(i)});
      exp_rd_q.push_back(AW'(i));
      if (corrupt[i]) begin
        e++;
        if (f < 0) f = i;
      end
    end
    exp_res_q.push_back({(e == 0), 16'(e), AW'((f < 0) ? 0 : f)});
  endtask

  task automatic run_test(input string tag, input int lat, input int wpct,
                          input int stall_idx, input int stall_len,
                          input logic [7:0] corrupt, input bit start_mid);
    int t0;
    @(negedge clk);
    cfg_lat = lat; cfg_wpct = wpct; cfg_stall_idx = stall_idx;
    stall_left = stall_len; wr_seen = 0; cfg_corrupt = corrupt;
    push_expect(corrupt);
    wr_acc_cnt = 0; rd_acc_cnt = 0; max_outst = 0; stall_cycles = 0;
    t0 = done_cnt;
    test_active = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (start_mid) begin
      for (int k = 0; k < 2000 && rd_acc_cnt < 2; k++) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int k = 0; k < 3000 && done_cnt == t0; k++) @(negedge clk);
    if (done_cnt == t0) begin
      fail_now({tag, "_done_timeout"});
      exp_wr_q.delete(); exp_rd_q.delete(); exp_res_q.delete();
    end
    wait_cycles(4);
    test_active = 0;
    check({tag, "_write_count"}, wr_acc_cnt, NW);
    check({tag, "_read_count"}, rd_acc_cnt, NW);
    check({tag, "_done_once"}, done_cnt - t0, 1);
    check({tag, "_idle_after"}, busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    wait_cycles(4);
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_first_err", first_err_addr, 0);
    check("rst_read", bus.avm_read, 0);
    check("rst_write", bus.avm_write, 0);
    check("rst_state", dbg_state, 0);
    check("rst_byteenable", bus.avm_byteenable, 2'b11);
    @(negedge clk);
    reset = 1'b0;
    wait_cycles(2);

    // Ideal slave: back-to-back writes then reads.
    run_test("ideal", 3, 0, -1, 0, 8'h00, 0);

    // Five-cycle stall on write index 2.
    run_test("wstall", 3, 0, 2, 5, 8'h00, 0);
    check("wstall_stall_cycles", stall_cycles, 5);

    // Long read latency: issue must stop at the outstanding cap.
    run_test("slow_rd", 20, 0, -1, 0, 8'h00, 0);
    check("slow_rd_max_outst", max_outst, MAXO);

    // Corrupt words at addresses 3 and 6.
    run_test("corrupt", 3, 0, -1, 0, 8'b0100_1000, 0);

    // start while busy is ignored.
    run_test("start_busy", 3, 0, -1, 0, 8'h00, 1);

    // Spurious readdatavalid while idle.
    @(negedge clk);
    spurious_req = 1;
    wait_cycles(3);
    check("spurious_err_cnt", err_cnt, 1);
    check("spurious_pass_held", pass, 1);
    check("spurious_idle", busy, 0);

    // Randomized slave behaviour and corruption.
    for (int n = 0; n < 12; n++) begin
      logic [7:0] cm;
      cm = 8'($urandom) & 8'($urandom);
      run_test("rand", $urandom_range(1, 8), $urandom_range(0, 40),
               $urandom_range(0, 7), $urandom_range(0, 4), cm, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of the read phase.
    begin
      int t0;
      @(negedge clk);
      cfg_lat = 3; cfg_wpct = 0; cfg_stall_idx = -1; stall_left = 0;
      wr_seen = 0; cfg_corrupt = 8'h01;
      push_expect(8'h01);
      wr_acc_cnt = 0; rd_acc_cnt = 0;
      t0 = done_cnt;
      test_active = 1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 2000 && rd_acc_cnt < 6; k++) @(negedge clk);
      check("mid_rst_err_before", err_cnt, 1);
      reset = 1'b1;
      @(negedge clk);
      #2;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_pass", pass, 0);
      check("mid_rst_err_cnt", err_cnt, 0);
      check("mid_rst_first_err", first_err_addr, 0);
      check("mid_rst_read", bus.avm_read, 0);
      check("mid_rst_write", bus.avm_write, 0);
      check("mid_rst_address", bus.avm_address, 0);
      reset = 1'b0;
      exp_wr_q.delete(); exp_rd_q.delete(); exp_res_q.delete();
      wait_cycles(30);
      check("mid_rst_no_done", done_cnt - t0, 0);
      check("mid_rst_err_after", err_cnt, 0);
    end

    // Recovery after the aborted test.
    run_test("recover", 2, 10, 1, 2, 8'b1000_0000, 0);

    // Address wrap: BASE = 2**AW-2, four words -> FFFFFE, FFFFFF, 0, 1.
    begin
      int t0;
      for (int i = 0; i < NW2; i++) begin
        logic [AW-1:0] a;
        a = BASE2 + AW'(i);
        exp_wr2_q.push_back({a, model_pat(i)});
        exp_rd2_q.push_back(a);
      end
      t0 = done2_cnt;
      @(negedge clk);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      for (int k = 0; k < 500 && done2_cnt == t0; k++) @(negedge clk);
      if (done2_cnt == t0) fail_now("wrap_done_timeout");
      wait_cycles(3);
      check("wrap_writes_consumed", exp_wr2_q.size(), 0);
      check("wrap_reads_consumed", exp_rd2_q.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
